// File: rtl/rf_multiport.sv
// Multi-port general-purpose register file with two bypassed write ports,
// a per-register pending scoreboard and a self-clearing array.
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int REG_NUM  = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       clr_req,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  output logic                       init_busy
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_NUM - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [REG_NUM];
  logic [REG_NUM-1:0] pend;
  logic              run;
  logic              wr0_we;
  logic              wr1_we;
  logic              iss_we;
  logic [ADDR_W-1:0] ra;

  // A real, architecturally visible register: in range and not the hardwired zero.
  function automatic logic is_real_reg(input logic [ADDR_W-1:0] a);
    return (32'(a) < REG_NUM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run       = (state == ST_RUN);
  assign init_busy = (state == ST_CLEAR);
  assign wr0_we    = run && wr0_en && is_real_reg(wr0_addr);
  assign wr1_we    = run && wr1_en && is_real_reg(wr1_addr);
  assign iss_we    = run && iss_en && is_real_reg(iss_addr);

  // Clear sequencer: clr_req restarts the sweep from register 0 in either state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (clr_req) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      if (cnt == LAST_ADDR) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: the array has no reset; the clear sweep zeroes it, which keeps it mappable to distributed RAM.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      if (wr0_we) regs[wr0_addr] <= wr0_data;
      // Issued after port 0 so the LSU port wins a same-address collision.
      if (wr1_we) regs[wr1_addr] <= wr1_data;
    end
  end

  // Scoreboard: writeback retires, issue allocates; allocation wins a same-cycle tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (state == ST_CLEAR || clr_req) begin
      pend <= '0;
    end else begin
      if (wr0_we) pend[wr0_addr] <= 1'b0;
      if (wr1_we) pend[wr1_addr] <= 1'b0;
      if (iss_we) pend[iss_addr] <= 1'b1;
    end
  end

  // Read ports with write-to-read bypass; port 1 has priority as it does for the array.
  // NOTE: every output and temporary gets a default first so no latch is inferred.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    ra      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (run && is_real_reg(ra)) begin
        if (wr1_en && (wr1_addr == ra)) begin
          rd_data[k*DATA_W +: DATA_W] = wr1_data;
        end else if (wr0_en && (wr0_addr == ra)) begin
          rd_data[k*DATA_W +: DATA_W] = wr0_data;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = regs[ra];
        end
        rd_pend[k] = pend[ra] && !((wr0_en && (wr0_addr == ra)) || (wr1_en && (wr1_addr == ra)));
      end
    end
  end

endmodule
